// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_pkg: shared types and constants for the PC fetch controller.
//   state_e     - sequencing FSM states (RUN, RESOLVE, REDIRECT, FLUSH)
//   COND_*      - 4-bit CR16 condition-code encodings
//   FLAG_*      - bit positions inside the {C,L,F,Z,N} flag vector
package pc_fetch_pkg;

  // Explicit encodings keep the state values identical to the legacy constants.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RESOLVE  = 2'd1,
    REDIRECT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: decode/flags/imem inputs and PC-control outputs of the
// fetch controller, bundled as one interface.
//   master modport - decode / pipeline side (drives i_*, observes o_*)
//   slave  modport - pc_fetch_ctrl (observes i_*, drives o_*)
interface pc_fetch_ctrl_if #(
  parameter int unsigned OFFSET_WIDTH = 8
);
  logic                    i_dec_valid;
  logic                    i_dec_bcond;
  logic                    i_dec_jump;
  logic [3:0]              i_dec_cond;
  logic [OFFSET_WIDTH-1:0] i_dec_disp;
  logic [4:0]              i_flags;
  logic                    i_flags_valid;
  logic                    i_imem_ready;
  logic                    i_hazard;

  logic                    o_stall;
  logic                    o_bcond;
  logic                    o_jump;
  logic [OFFSET_WIDTH-1:0] o_disp;
  logic                    o_nop;
  logic                    o_busy;
  logic                    o_timeout;

  modport master (
    output i_dec_valid, i_dec_bcond, i_dec_jump, i_dec_cond, i_dec_disp,
           i_flags, i_flags_valid, i_imem_ready, i_hazard,
    input  o_stall, o_bcond, o_jump, o_disp, o_nop, o_busy, o_timeout
  );

  modport slave (
    input  i_dec_valid, i_dec_bcond, i_dec_jump, i_dec_cond, i_dec_disp,
           i_flags, i_flags_valid, i_imem_ready, i_hazard,
    output o_stall, o_bcond, o_jump, o_disp, o_nop, o_busy, o_timeout
  );
endinterface

// File: rtl/pc_fetch_ctrl_cond_eval.sv
// pc_cond_eval: combinational CR16 condition-code resolver.
//   cond_i  - 4-bit condition field
//   flags_i - {C,L,F,Z,N} status flags
//   taken_o - 1 when the condition holds
module pc_cond_eval
  import pc_fetch_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       taken_o
);

  logic c, l, f, z, n;

  always_comb begin
    c = flags_i[FLAG_C];
    l = flags_i[FLAG_L];
    f = flags_i[FLAG_F];
    z = flags_i[FLAG_Z];
    n = flags_i[FLAG_N];
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = ~z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = ~c;
      COND_HI: taken_o = l;
      COND_LS: taken_o = ~l;
      COND_GT: taken_o = n;
      COND_LE: taken_o = ~n;
      COND_FS: taken_o = f;
      COND_FC: taken_o = ~f;
      COND_LO: taken_o = ~l & ~z;
      COND_HS: taken_o = l | z;
      COND_LT: taken_o = ~n & ~z;
      COND_GE: taken_o = n | z;
      COND_UC: taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: sequencing controller for the program-counter register.
// Accepts branches from decode, waits for the flags to settle, resolves the
// condition, pulses the PC redirect controls and inserts NOP bubbles.
//   i_sys_clk, i_sys_rstn - clock, asynchronous active-low reset
//   bus (slave)           - decode/flags/imem inputs, PC-control outputs
//   o_perf_taken/bubble   - saturating event counters, present only when
//                           PC_FETCH_CTRL_PERF_EN is defined
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int unsigned OFFSET_WIDTH = 8,
  parameter int unsigned FLUSH_SLOTS  = 1,
  parameter int unsigned MAX_WAIT     = 7
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rstn,
  pc_fetch_ctrl_if.slave   bus
`ifdef PC_FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]      o_perf_taken,
  output logic [15:0]      o_perf_bubble
`endif
);

  localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_SLOTS);

  state_e                  state_q, state_d;
  logic [3:0]              wait_q, wait_d;
  logic [1:0]              flush_q, flush_d;
  logic [3:0]              cond_q, cond_d;
  logic                    jump_q, jump_d;
  logic                    taken_q, taken_d;
  logic                    timeout_q, timeout_d;
  logic [OFFSET_WIDTH-1:0] disp_q, disp_d;

  logic cond_taken;
  logic accept;

  pc_cond_eval u_cond_eval (
    .cond_i  (cond_q),
    .flags_i (bus.i_flags),
    .taken_o (cond_taken)
  );

  assign accept = bus.i_dec_valid & (bus.i_dec_bcond | bus.i_dec_jump) &
                  bus.i_imem_ready & ~bus.i_hazard;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    flush_d   = flush_q;
    cond_d    = cond_q;
    jump_d    = jump_q;
    taken_d   = taken_q;
    timeout_d = timeout_q;
    disp_d    = disp_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          cond_d  = bus.i_dec_cond;
          // Jcond takes priority when decode flags both types.
          jump_d  = bus.i_dec_jump;
          disp_d  = bus.i_dec_disp;
          wait_d  = '0;
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        wait_d = wait_q + 4'd1;
        if (bus.i_flags_valid) begin
          taken_d = cond_taken;
          state_d = REDIRECT;
        end else if (wait_q == WAIT_LAST) begin
          // MAX_WAIT cycles spent here without valid flags: give up, fall through.
          taken_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = REDIRECT;
        end
      end
      REDIRECT: begin
        if (taken_q) begin
          flush_d = FLUSH_INIT;
          state_d = FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (bus.i_imem_ready) begin
          if (flush_q == 2'd1) state_d = RUN;
          else                 flush_d = flush_q - 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      state_q   <= RUN;
      wait_q    <= '0;
      flush_q   <= '0;
      cond_q    <= '0;
      jump_q    <= 1'b0;
      taken_q   <= 1'b0;
      timeout_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      flush_q   <= flush_d;
      cond_q    <= cond_d;
      jump_q    <= jump_d;
      taken_q   <= taken_d;
      timeout_q <= timeout_d;
      disp_q    <= disp_d;
    end
  end

  // Outputs decode the registered state; only the RUN and FLUSH stall terms
  // follow the live imem/hazard inputs.
  always_comb begin
    bus.o_stall = 1'b0;
    case (state_q)
      RUN:      bus.o_stall = ~bus.i_imem_ready | bus.i_hazard;
      RESOLVE:  bus.o_stall = 1'b1;
      REDIRECT: bus.o_stall = 1'b0;
      FLUSH:    bus.o_stall = ~bus.i_imem_ready;
      default:  bus.o_stall = 1'b0;
    endcase
  end

  assign bus.o_nop     = (state_q != RUN);
  assign bus.o_busy    = (state_q != RUN);
  assign bus.o_bcond   = (state_q == REDIRECT) & taken_q & ~jump_q;
  assign bus.o_jump    = (state_q == REDIRECT) & taken_q &  jump_q;
  assign bus.o_disp    = disp_q;
  assign bus.o_timeout = timeout_q;

`ifdef PC_FETCH_CTRL_PERF_EN
  logic [15:0] perf_taken_q, perf_bubble_q;

  always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      perf_taken_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if ((state_q == REDIRECT) && taken_q && (perf_taken_q != '1))
        perf_taken_q <= perf_taken_q + 16'd1;
      if ((state_q != RUN) && (perf_bubble_q != '1))
        perf_bubble_q <= perf_bubble_q + 16'd1;
    end
  end

  assign o_perf_taken  = perf_taken_q;
  assign o_perf_bubble = perf_bubble_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  localparam int unsigned OW = 8;
  localparam int unsigned FS = 1;
  localparam int unsigned MW = 7;

  localparam logic [4:0] FZ = 5'b00010;
  localparam logic [4:0] FC = 5'b10000;
  localparam logic [4:0] FN = 5'b00001;
  localparam logic [4:0] FL = 5'b01000;

  typedef struct packed {
    logic       stall;
    logic       nop;
    logic       busy;
    logic       bcond;
    logic       jump;
    logic       tmo;
    logic [7:0] disp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.OFFSET_WIDTH(OW)) bus ();

`ifdef PC_FETCH_CTRL_PERF_EN
  logic [15:0] perf_taken, perf_bubble;
`endif

  pc_fetch_ctrl #(
    .OFFSET_WIDTH (OW),
    .FLUSH_SLOTS  (FS),
    .MAX_WAIT     (MW)
  ) dut (
    .i_sys_clk  (clk),
    .i_sys_rstn (rst_n),
    .bus        (bus)
`ifdef PC_FETCH_CTRL_PERF_EN
    ,
    .o_perf_taken  (perf_taken),
    .o_perf_bubble (perf_bubble)
`endif
  );

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  exp_t expq[$];

  // Model state: last accepted displacement and sticky timeout.
  logic [7:0] disp_exp = '0;
  logic       tmo_exp  = 1'b0;

  // DUT activity monitors for pinning the model with hand-computed totals.
  int nop_cnt = 0, bcond_cnt = 0, jump_cnt = 0;
  int nop_b, bcond_b, jump_b;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, got, req);
  endtask

  function automatic logic ref_taken(input logic [3:0] c, input logic [4:0] f);
    logic cf, lf, ff, zf, nf;
    {cf, lf, ff, zf, nf} = f;
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return lf;
      4'd5:  return !lf;
      4'd6:  return nf;
      4'd7:  return !nf;
      4'd8:  return ff;
      4'd9:  return !ff;
      4'd10: return !lf && !zf;
      4'd11: return lf || zf;
      4'd12: return !nf && !zf;
      4'd13: return nf || zf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t mk(input logic st, np, by, bc, jp);
    exp_t e;
    e.stall = st; e.nop = np; e.busy = by; e.bcond = bc; e.jump = jp;
    e.tmo = tmo_exp; e.disp = disp_exp;
    return e;
  endfunction

  // Single compare process: one expected vector per driven cycle.
  always @(negedge clk) begin
    exp_t e, g;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      g.stall = bus.o_stall; g.nop = bus.o_nop; g.busy = bus.o_busy;
      g.bcond = bus.o_bcond; g.jump = bus.o_jump; g.tmo = bus.o_timeout;
      g.disp = bus.o_disp;
      cyc++;
      checks++;
      if (g === e) passes++;
      else $display("FAIL cycle%0d outputs: got %h required %h", cyc, g, e);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      nop_cnt   += int'(bus.o_nop);
      bcond_cnt += int'(bus.o_bcond);
      jump_cnt  += int'(bus.o_jump);
    end
  end

  task automatic step(input logic v, bc, jp, input logic [3:0] c, input logic [7:0] d,
                      input logic [4:0] f, input logic fv, rdy, hz, input exp_t e);
    @(posedge clk); #1;
    bus.i_dec_valid = v; bus.i_dec_bcond = bc; bus.i_dec_jump = jp;
    bus.i_dec_cond = c; bus.i_dec_disp = d; bus.i_flags = f;
    bus.i_flags_valid = fv; bus.i_imem_ready = rdy; bus.i_hazard = hz;
    expq.push_back(e);
  endtask

  task automatic idle(input logic rdy, hz);
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 5'd0, 1'b0, rdy, hz, mk(!rdy || hz, 0, 0, 0, 0));
  endtask

  // One complete branch. fv_at: RESOLVE cycle index in which flags become
  // valid (negative = never). hz: hazard cycles before accept. nr: FLUSH
  // cycles with imem not ready.
  task automatic do_branch(input logic [3:0] c, input logic jp, bc, input logic [7:0] d,
                           input logic [4:0] f, input int fv_at, hz, nr);
    int   nres;
    logic tmo, tk;
    for (int i = 0; i < hz; i++) step(1, bc, jp, c, d, f, 0, 1, 1, mk(1, 0, 0, 0, 0));
    step(1, bc, jp, c, d, f, fv_at == 0, 1, 0, mk(0, 0, 0, 0, 0));
    disp_exp = d;
    tmo  = (fv_at < 0) || (fv_at >= int'(MW));
    nres = tmo ? int'(MW) : fv_at + 1;
    // hazard high and imem not ready here: both must be ignored
    for (int i = 0; i < nres; i++) step(0, 0, 0, c, d, f, i == fv_at, 0, 1, mk(1, 1, 1, 0, 0));
    if (tmo) tmo_exp = 1'b1;
    tk = !tmo && ref_taken(c, f);
    step(0, 0, 0, c, d, f, 0, 1, 0, mk(0, 1, 1, tk && !jp, tk && jp));
    if (tk) begin
      for (int i = 0; i < nr; i++) step(0, 0, 0, c, d, f, 0, 0, 0, mk(1, 1, 1, 0, 0));
      for (int i = 0; i < int'(FS); i++) step(0, 0, 0, c, d, f, 0, 1, 0, mk(0, 1, 1, 0, 0));
    end
    idle(1'b1, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic snap();
    nop_b = nop_cnt; bcond_b = bcond_cnt; jump_b = jump_cnt;
  endtask

  initial begin
    bus.i_dec_valid = 0; bus.i_dec_bcond = 0; bus.i_dec_jump = 0;
    bus.i_dec_cond = '0; bus.i_dec_disp = '0; bus.i_flags = '0;
    bus.i_flags_valid = 0; bus.i_imem_ready = 1; bus.i_hazard = 0;
    #3;
    check("rst_stall", {31'd0, bus.o_stall}, 0);
    check("rst_busy_nop", {30'd0, bus.o_busy, bus.o_nop}, 0);
    check("rst_pulses", {30'd0, bus.o_bcond, bus.o_jump}, 0);
    check("rst_disp_tmo", {23'd0, bus.o_timeout, bus.o_disp}, 0);
    #9 rst_n = 1'b1;

    idle(1'b0, 1'b0);
    idle(1'b1, 1'b1);

    // BEQ taken, flags valid in the second RESOLVE cycle
    snap();
    do_branch(4'b0000, 0, 1, 8'h05, FZ, 1, 0, 0);
    settle();
    check("beq_nops", nop_cnt - nop_b, 4);
    check("beq_bcond", bcond_cnt - bcond_b, 1);
    check("beq_disp", {24'd0, bus.o_disp}, 32'h05);

    // BNE with Z=1: not taken, no flush
    snap();
    do_branch(4'b0001, 0, 1, 8'h22, FZ, 0, 0, 0);
    settle();
    check("bne_nops", nop_cnt - nop_b, 2);
    check("bne_pulses", (bcond_cnt - bcond_b) + (jump_cnt - jump_b), 0);

    // JUC with flags already valid at accept
    snap();
    do_branch(4'b1110, 1, 0, 8'h80, 5'd0, 0, 0, 0);
    settle();
    check("juc_jump", jump_cnt - jump_b, 1);
    check("juc_nops", nop_cnt - nop_b, 2 + FS);

    // hazard holds the branch for 3 cycles; FLUSH sees 2 not-ready cycles
    do_branch(4'b0010, 0, 1, 8'h7F, FC, 2, 3, 2);
    do_branch(4'b1111, 1, 0, 8'h01, 5'h1F, 0, 0, 0);
    do_branch(4'b1010, 0, 1, 8'hF0, 5'd0, 0, 0, 0);
    do_branch(4'b1011, 0, 1, 8'h0F, 5'd0, 1, 0, 0);
    do_branch(4'b1101, 1, 0, 8'hAA, FN, 0, 0, 1);
    do_branch(4'b1100, 0, 1, 8'h3C, FN, 0, 0, 0);
    do_branch(4'b1000, 0, 1, 8'h3D, 5'b00100, 0, 0, 0);

    // both type bits set: jump wins
    snap();
    do_branch(4'b1110, 1, 1, 8'h55, 5'd0, 0, 0, 0);
    settle();
    check("both_jump", jump_cnt - jump_b, 1);
    check("both_bcond", bcond_cnt - bcond_b, 0);

    // flags never valid: timeout after MAX_WAIT, UC branch not taken
    snap();
    do_branch(4'b1110, 0, 1, 8'h33, FZ, -1, 0, 0);
    settle();
    check("tmo_flag", {31'd0, bus.o_timeout}, 1);
    check("tmo_nops", nop_cnt - nop_b, 8);
    check("tmo_bcond", bcond_cnt - bcond_b, 0);

    do_branch(4'b0100, 0, 1, 8'h44, FL, 0, 0, 0);

    // reset in the middle of RESOLVE
    step(1, 1, 0, 4'b0000, 8'h99, FZ, 0, 1, 0, mk(0, 0, 0, 0, 0));
    disp_exp = 8'h99;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000, 8'h99, FZ, 0, 1, 0, mk(1, 1, 1, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, bus.o_busy}, 0);
    check("mid_rst_tmo", {31'd0, bus.o_timeout}, 0);
    check("mid_rst_disp", {24'd0, bus.o_disp}, 0);
    tmo_exp = 1'b0;
    disp_exp = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;

    idle(1'b1, 1'b0);
    do_branch(4'b0000, 1, 0, 8'h12, FZ, 3, 0, 0);
    settle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
